// File: rtl/common_pkg.sv
// Shared types for the queue drain path: skid-stage FSM encoding and depth.
package common_pkg;

    typedef enum logic [1:0] {
        DRAIN_EMPTY,
        DRAIN_ONE,
        DRAIN_TWO
    } drain_state_e;

    localparam int DRAIN_DEPTH = 2;

endpackage

// File: rtl/fifo_drain_stage.sv
// Pops fifo_buffer entries into a two-entry main/skid register and presents them as a registered valid/ready stream.
// Optional stall counter port and logic are built only when FIFO_DRAIN_STALL_CNT_EN is defined.
module fifo_drain_stage
    import common_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rready_o,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
`ifdef FIFO_DRAIN_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
`endif
);

    drain_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  run_q;
    logic                  pop;
    logic                  fire;

    // run_q holds off popping until the first edge after reset release.
    assign fifo_rready_o = run_q & (state_q != DRAIN_TWO) & ~flush_i & ~fifo_empty_i;
    assign pop           = fifo_rready_o;
    assign valid_o       = (state_q != DRAIN_EMPTY);
    assign fire          = valid_o & ready_i;
    assign data_o        = main_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            DRAIN_EMPTY: begin
                if (pop) begin
                    main_d  = fifo_rdata_i;
                    state_d = DRAIN_ONE;
                end
            end
            DRAIN_ONE: begin
                if (pop && fire) begin
                    main_d = fifo_rdata_i;
                end else if (pop) begin
                    skid_d  = fifo_rdata_i;
                    state_d = DRAIN_TWO;
                end else if (fire) begin
                    state_d = DRAIN_EMPTY;
                end
            end
            DRAIN_TWO: begin
                if (fire) begin
                    main_d  = skid_q;
                    state_d = DRAIN_ONE;
                end
            end
            default: state_d = DRAIN_EMPTY;
        endcase
        // Flush discards held entries and wins over a simultaneous fire.
        if (flush_i) begin
            state_d = DRAIN_EMPTY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DRAIN_EMPTY;
            // NOTE: the data registers are reset too, since data_o must read zero out of reset.
            main_q  <= '0;
            skid_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            run_q   <= 1'b1;
        end
    end

`ifdef FIFO_DRAIN_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_o <= '0;
        end else if (flush_i) begin
            stall_cnt_o <= '0;
        end else if (valid_o && !ready_i && !(&stall_cnt_o)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_drain_stage.sv
// Bench for fifo_drain_stage: a queue-based fifo model feeds the DUT, a scoreboard tracks entries held in the stage.
module tb_fifo_drain_stage;
    import common_pkg::*;

    localparam int DW    = 16;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] fifo_rdata_i;
    logic          fifo_empty_i;
    logic          fifo_rready_o;
    logic          flush_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
`ifdef FIFO_DRAIN_STALL_CNT_EN
    logic [CW-1:0] stall_cnt_o;
`endif

    fifo_drain_stage #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fifo_rdata_i  (fifo_rdata_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_rready_o (fifo_rready_o),
        .flush_i       (flush_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i)
`ifdef FIFO_DRAIN_STALL_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          push_en;
        logic [DW-1:0] push_data;
        logic          rdy;
        logic          fl;
        logic          exp_valid;
        logic          exp_rready;
        logic          chk_data;
        logic [DW-1:0] exp_data;
    } vec_t;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] sb_q[$];
    int            n_vec = 0;
    int            n_bad = 0;
    bit            running = 1'b0;
    int            stall_exp = 0;
    vec_t          tab[17];
    vec_t          nov;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at the negedge, compare 1 time unit later, advance models, move to next negedge.
    task automatic step(input logic rdy, input logic fl, input logic gate,
                        input logic use_tab, input vec_t tv);
        logic ev, er;
        ready_i      = rdy;
        flush_i      = fl;
        fifo_empty_i = gate || (src_q.size() == 0);
        fifo_rdata_i = (src_q.size() != 0) ? src_q[0] : '0;
        #1;
        ev = (sb_q.size() != 0);
        er = running && (sb_q.size() < DRAIN_DEPTH) && !fl && !fifo_empty_i;
        check("valid_o", 32'(valid_o), 32'(ev));
        check("fifo_rready_o", 32'(fifo_rready_o), 32'(er));
`ifdef FIFO_DRAIN_STALL_CNT_EN
        check("stall_cnt_o", 32'(stall_cnt_o), 32'(stall_exp));
`endif
        if (use_tab) begin
            check("tab_valid", 32'(valid_o), 32'(tv.exp_valid));
            check("tab_rready", 32'(fifo_rready_o), 32'(tv.exp_rready));
            if (tv.chk_data) check("tab_data", 32'(data_o), 32'(tv.exp_data));
        end
        if (ev) check("data_o", 32'(data_o), 32'(sb_q[0]));
        if (ev && rdy && !fl) void'(sb_q.pop_front());
        if (fl) sb_q.delete();
        if (er) sb_q.push_back(src_q.pop_front());
        if (fl) stall_exp = 0;
        else if (ev && !rdy && stall_exp != CMAX) stall_exp++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, nov);
    endtask

    initial begin
        nov = '{default: 0};
        //            push  data      rdy   fl    valid rready chk   data
        tab[0]  = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        tab[1]  = '{1'b1, 16'h00A2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A1};
        tab[2]  = '{1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A1};
        tab[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A1};
        tab[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A1};
        tab[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A2};
        tab[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A3};
        tab[7]  = '{1'b1, 16'h00C1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A3};
        tab[8]  = '{1'b1, 16'h00B0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00A3};
        tab[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        tab[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00B0};
        tab[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tab[12] = '{1'b1, 16'h00D0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        tab[13] = '{1'b1, 16'h00D1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00D0};
        tab[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        tab[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00D1};
        tab[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

        // Reset with a non-empty fifo: nothing may pop until after release.
        reset_n      = 1'b0;
        ready_i      = 1'b0;
        flush_i      = 1'b0;
        src_q.push_back(16'h0055);
        fifo_empty_i = 1'b0;
        fifo_rdata_i = 16'h0055;
        @(negedge clk);
        #1;
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_rready", 32'(fifo_rready_o), 32'd0);
        check("reset_data", 32'(data_o), 32'd0);
`ifdef FIFO_DRAIN_STALL_CNT_EN
        check("reset_stall", 32'(stall_cnt_o), 32'd0);
`endif
        reset_n = 1'b1;
        #1;
        check("release_rready", 32'(fifo_rready_o), 32'd0);
        @(negedge clk);
        running = 1'b1;

        // Streaming at full throughput.
        for (int i = 1; i <= 8; i++) src_q.push_back(16'(i));
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0, nov);

        // Fifo empty flag toggling every cycle.
        for (int i = 0; i < 6; i++) src_q.push_back(16'h0010 + 16'(i));
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'(i % 2), 1'b0, nov);
        drain();

        // Backpressure, skid, flush and flush-over-fire vectors.
        for (int i = 0; i < 17; i++) begin
            if (tab[i].push_en) src_q.push_back(tab[i].push_data);
            step(tab[i].rdy, tab[i].fl, 1'b0, 1'b1, tab[i]);
        end
        drain();

`ifdef FIFO_DRAIN_STALL_CNT_EN
        src_q.push_back(16'h00E0);
        for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 1'b0, 1'b0, nov);
        check("stall_saturated", 32'(stall_cnt_o), 32'(CMAX));
        step(1'b0, 1'b1, 1'b0, 1'b0, nov);
        check("stall_flushed", 32'(stall_cnt_o), 32'd0);
        drain();
`endif

        // Mixed random traffic.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(2) == 0) src_q.push_back(16'($urandom));
            step(1'($urandom_range(3) != 0), 1'($urandom_range(15) == 0),
                 1'($urandom_range(4) == 0), 1'b0, nov);
        end
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0, 1'b0, nov);
        check("final_stage_empty", 32'(sb_q.size()), 32'd0);
        check("final_fifo_empty", 32'(src_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
